// File: rtl/irq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : irq_scheduler
// Purpose  : Interrupt controller between the mapper's interrupt sources and
//            the Z80 INT pin. Latches rising edges on N_SRC request lines,
//            arbitrates them with fixed or rotating priority, runs the IM2
//            acknowledge handshake (even vector on the data bus), and keeps
//            further interrupts off until the service routine writes EOI.
//            While hold is high, irq_n is kept high but requests still pend.
// Ports    : clk, reset_n          clock, asynchronous active-low reset
//            m1_n, iorq_n          Z80 bus strobes (synchronous to clk)
//            req[N_SRC]            per-source edge-triggered requests
//            hold                  trap-state gate for delivery
//            cfg_wr/rd/addr/wdata  register access; cfg_rdata combinational
//            irq_n                 registered interrupt to CPU
//            vector, vector_oe     IM2 vector byte and its bus enable
//            in_service            high from acknowledge until EOI
// Revision : 1.0 - initial release
// ============================================================================
module irq_scheduler #(
    parameter int         N_SRC    = 4,
    parameter logic [7:0] VEC_BASE = 8'hE0,
    parameter logic [7:0] SPUR_VEC = 8'hFE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             m1_n,
    input  logic             iorq_n,
    input  logic [N_SRC-1:0] req,
    input  logic             hold,
    input  logic             cfg_wr,
    input  logic             cfg_rd,
    input  logic [1:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    output logic [7:0]       cfg_rdata,
    output logic             irq_n,
    output logic [7:0]       vector,
    output logic             vector_oe,
    output logic             in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_ACK     = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

    localparam logic [1:0] C_ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] C_ADDR_PENDING = 2'd1;
    localparam logic [1:0] C_ADDR_EOI     = 2'd2;
    localparam logic [1:0] C_ADDR_ROTATE  = 2'd3;
    localparam logic [2:0] C_LAST_ID      = 3'(N_SRC - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [N_SRC-1:0] r_req_q;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_enable;
    logic             r_rotate;
    logic [2:0]       r_rr_ptr;
    logic [2:0]       r_id;
    logic             r_ack_q;
    logic             r_hold_q;
    logic             r_irq_n;
    logic [7:0]       r_vector;
    logic             r_vector_oe;
    logic             r_in_service;

    logic             w_ack;
    logic             w_ack_rise;
    logic [N_SRC-1:0] w_eligible;
    logic [7:0]       w_elig8;
    logic [2:0]       w_base;
    logic [2:0]       w_winner;
    logic             w_take;
    logic             w_spur;
    logic             w_eoi;
    logic [N_SRC-1:0] w_set;
    logic [N_SRC-1:0] w_clr;
    logic [7:0]       w_clr8;
    logic             w_unused_wdata;

    assign w_ack      = ~m1_n & ~iorq_n;
    assign w_ack_rise = w_ack & ~r_ack_q;
    assign w_eligible = r_pending & r_enable;

    // Genuine acknowledge of the asserted source vs. an acknowledge that
    // arrives with nothing granted (answered with SPUR_VEC only).
    assign w_take = (r_state == ST_ASSERT) & w_ack_rise;
    assign w_spur = w_ack_rise & ((r_state == ST_IDLE) | (r_state == ST_SERVICE));
    assign w_eoi  = cfg_wr & (cfg_addr == C_ADDR_EOI) & (r_state == ST_SERVICE);

    // Hardware edges plus software write-1-sets; these win over the clear.
    assign w_set  = (req & ~r_req_q)
                  | ((cfg_wr && cfg_addr == C_ADDR_PENDING) ? cfg_wdata[N_SRC-1:0] : '0);
    assign w_clr8 = 8'd1 << r_id;
    assign w_clr  = w_take ? w_clr8[N_SRC-1:0] : '0;

    assign w_unused_wdata = ^cfg_wdata;

    // Widen eligibility to 8 bits so a 3-bit id can index it for any N_SRC.
    always_comb begin
        w_elig8               = '0;
        w_elig8[N_SRC-1:0]    = w_eligible;
    end

    // Search starts at rr_ptr in rotate mode, at 0 in fixed mode. Scanning
    // offsets from the far end down leaves the nearest eligible index.
    assign w_base = r_rotate ? r_rr_ptr : 3'd0;

    always_comb begin
        int j;
        w_winner = 3'd0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            j = int'(w_base) + k;
            if (j >= N_SRC) begin
                j = j - N_SRC;
            end
            if (w_elig8[3'(j)]) begin
                w_winner = 3'(j);
            end
        end
    end

    // Next-state logic. Hold must have been low for a full cycle before a new
    // interrupt starts, but retraction in ASSERT reacts to raw hold at once.
    // An acknowledge in ASSERT takes precedence over retraction: the CPU has
    // already committed to the bus cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!hold && !r_hold_q && (|w_eligible)) begin
                    w_state_next = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (w_ack_rise) begin
                    w_state_next = ST_ACK;
                end else if (!w_elig8[r_id] || hold) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!w_ack) begin
                    w_state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (w_eoi) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_q      <= '0;
            r_pending    <= '0;
            r_enable     <= '0;
            r_rotate     <= 1'b0;
            r_rr_ptr     <= 3'd0;
            r_id         <= 3'd0;
            r_ack_q      <= 1'b0;
            r_hold_q     <= 1'b0;
            r_irq_n      <= 1'b1;
            r_vector     <= 8'h00;
            r_vector_oe  <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_req_q   <= req;
            r_ack_q   <= w_ack;
            r_hold_q  <= hold;
            r_pending <= (r_pending & ~w_clr) | w_set;

            if (cfg_wr && cfg_addr == C_ADDR_ENABLE) begin
                r_enable <= cfg_wdata[N_SRC-1:0];
            end
            if (cfg_wr && cfg_addr == C_ADDR_ROTATE) begin
                r_rotate <= cfg_wdata[0];
            end

            // The winner is frozen when leaving IDLE.
            if (r_state == ST_IDLE && w_state_next == ST_ASSERT) begin
                r_id <= w_winner;
            end

            r_irq_n <= (w_state_next != ST_ASSERT);

            if (w_take) begin
                r_vector <= VEC_BASE + {4'b0000, r_id, 1'b0};
            end else if (w_spur) begin
                r_vector <= SPUR_VEC;
            end

            if (w_take || w_spur) begin
                r_vector_oe <= 1'b1;
            end else if (!w_ack) begin
                r_vector_oe <= 1'b0;
            end

            if (w_take) begin
                r_in_service <= 1'b1;
            end else if (w_eoi) begin
                r_in_service <= 1'b0;
            end

            if (w_eoi && r_rotate) begin
                r_rr_ptr <= (r_id == C_LAST_ID) ? 3'd0 : r_id + 3'd1;
            end
        end
    end

    always_comb begin
        cfg_rdata = 8'h00;
        if (cfg_rd) begin
            case (cfg_addr)
                C_ADDR_ENABLE:  cfg_rdata[N_SRC-1:0] = r_enable;
                C_ADDR_PENDING: cfg_rdata[N_SRC-1:0] = r_pending;
                C_ADDR_EOI:     cfg_rdata = {r_in_service, 4'b0000, r_id};
                C_ADDR_ROTATE:  cfg_rdata = {7'b0000000, r_rotate};
                default:        cfg_rdata = 8'h00;
            endcase
        end
    end

    assign irq_n      = r_irq_n;
    assign vector     = r_vector;
    assign vector_oe  = r_vector_oe;
    assign in_service = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_irq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_scheduler
// Purpose  : Self-checking bench for irq_scheduler (N_SRC=4). Directed
//            scenarios followed by a randomized run against a behavioural
//            pending/priority model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_scheduler;

    localparam int         N  = 4;
    localparam logic [7:0] VB = 8'hE0;
    localparam logic [7:0] SV = 8'hFE;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         m1_n;
    logic         iorq_n;
    logic [N-1:0] req;
    logic         hold;
    logic         cfg_wr;
    logic         cfg_rd;
    logic [1:0]   cfg_addr;
    logic [7:0]   cfg_wdata;
    logic [7:0]   cfg_rdata;
    logic         irq_n;
    logic [7:0]   vector;
    logic         vector_oe;
    logic         in_service;

    int n_checks = 0;
    int n_fail   = 0;

    irq_scheduler #(.N_SRC(N), .VEC_BASE(VB), .SPUR_VEC(SV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m1_n       (m1_n),
        .iorq_n     (iorq_n),
        .req        (req),
        .hold       (hold),
        .cfg_wr     (cfg_wr),
        .cfg_rd     (cfg_rd),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .irq_n      (irq_n),
        .vector     (vector),
        .vector_oe  (vector_oe),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_addr  = a;
        cfg_wdata = d;
        cfg_wr    = 1'b1;
        tick();
        cfg_wr    = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [7:0] d);
        cfg_addr = a;
        cfg_rd   = 1'b1;
        #1;
        d        = cfg_rdata;
        cfg_rd   = 1'b0;
    endtask

    task automatic ack_start();
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        tick();
    endtask

    task automatic ack_end();
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        reset_n = 1'b0; m1_n = 1'b1; iorq_n = 1'b1; req = '0; hold = 1'b0;
        cfg_wr = 1'b0; cfg_rd = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
        tick(2);
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL reset_irq_n got %b want 1", irq_n); end
        n_checks++; if (vector_oe !== 1'b0) begin n_fail++; $display("FAIL reset_vector_oe got %b want 0", vector_oe); end
        n_checks++; if (vector !== 8'h00) begin n_fail++; $display("FAIL reset_vector got %h want 00", vector); end
        n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_in_service got %b want 0", in_service); end
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            cfg_read(2'(a), rd);
            n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d got %h want 00", a, rd); end
        end
        n_checks++; if (cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL rdata_no_rd got %h want 00", cfg_rdata); end
    endtask

    task automatic test_basic();
        logic [7:0] rd;
        cfg_write(2'd0, 8'h0F);
        cfg_write(2'd3, 8'h00);
        req = 4'b0100; tick(); req = '0;
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL basic_irq_early got %b want 1", irq_n); end
        cfg_read(2'd1, rd);
        n_checks++; if (rd !== 8'h04) begin n_fail++; $display("FAIL basic_pending got %h want 04", rd); end
        tick();
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL basic_irq_low got %b want 0", irq_n); end
        ack_start();
        n_checks++; if (vector !== 8'hE4) begin n_fail++; $display("FAIL basic_vector got %h want e4", vector); end
        n_checks++; if (vector_oe !== 1'b1) begin n_fail++; $display("FAIL basic_oe got %b want 1", vector_oe); end
        n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL basic_in_service got %b want 1", in_service); end
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL basic_irq_after_ack got %b want 1", irq_n); end
        cfg_read(2'd1, rd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL basic_pending_clr got %h want 00", rd); end
        tick();
        n_checks++; if (vector_oe !== 1'b1) begin n_fail++; $display("FAIL basic_oe_hold got %b want 1", vector_oe); end
        ack_end();
        n_checks++; if (vector_oe !== 1'b0) begin n_fail++; $display("FAIL basic_oe_drop got %b want 0", vector_oe); end
        req = 4'b0001; tick(); req = '0;
        tick(3);
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL basic_irq_in_service got %b want 1", irq_n); end
        cfg_read(2'd2, rd);
        n_checks++; if (rd !== 8'h82) begin n_fail++; $display("FAIL basic_reg2 got %h want 82", rd); end
        cfg_write(2'd2, 8'h00);
        n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL basic_eoi got %b want 0", in_service); end
        tick();
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL basic_queued_irq got %b want 0", irq_n); end
        ack_start();
        n_checks++; if (vector !== 8'hE0) begin n_fail++; $display("FAIL basic_queued_vec got %h want e0", vector); end
        ack_end();
        cfg_write(2'd2, 8'h00);
    endtask

    task automatic test_fixed_priority();
        req = 4'b1010; tick(); req = '0; tick();
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL fixed_irq got %b want 0", irq_n); end
        ack_start();
        n_checks++; if (vector !== 8'hE2) begin n_fail++; $display("FAIL fixed_first got %h want e2", vector); end
        ack_end();
        cfg_write(2'd2, 8'h00);
        tick();
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL fixed_irq2 got %b want 0", irq_n); end
        ack_start();
        n_checks++; if (vector !== 8'hE6) begin n_fail++; $display("FAIL fixed_second got %h want e6", vector); end
        ack_end();
        cfg_write(2'd2, 8'h00);
    endtask

    task automatic test_rotate();
        logic [7:0] rd;
        cfg_write(2'd3, 8'h01);
        req = 4'b0001; tick(); req = '0; tick();
        ack_start();
        n_checks++; if (vector !== 8'hE0) begin n_fail++; $display("FAIL rot_src0 got %h want e0", vector); end
        ack_end();
        cfg_write(2'd2, 8'h00);
        req = 4'b0011; tick(); req = '0; tick();
        ack_start();
        n_checks++; if (vector !== 8'hE2) begin n_fail++; $display("FAIL rot_ptr1 got %h want e2", vector); end
        ack_end();
        cfg_write(2'd2, 8'h00);
        tick();
        ack_start();
        n_checks++; if (vector !== 8'hE0) begin n_fail++; $display("FAIL rot_wrap got %h want e0", vector); end
        ack_end();
        cfg_write(2'd2, 8'h00);
        cfg_read(2'd3, rd);
        n_checks++; if (rd !== 8'h01) begin n_fail++; $display("FAIL rot_reg3 got %h want 01", rd); end
        cfg_write(2'd3, 8'hFE);
        cfg_read(2'd3, rd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rot_reg3_clr got %h want 00", rd); end
    endtask

    task automatic test_hold();
        logic [7:0] rd;
        hold = 1'b1;
        req = 4'b0001; tick(); req = '0;
        tick(3);
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL hold_irq got %b want 1", irq_n); end
        cfg_read(2'd1, rd);
        n_checks++; if (rd !== 8'h01) begin n_fail++; $display("FAIL hold_pending got %h want 01", rd); end
        hold = 1'b0;
        tick();
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL hold_release1 got %b want 1", irq_n); end
        tick();
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL hold_release2 got %b want 0", irq_n); end
        hold = 1'b1;
        tick();
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL hold_retract got %b want 1", irq_n); end
        hold = 1'b0;
        tick(2);
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL hold_reassert got %b want 0", irq_n); end
        ack_start();
        n_checks++; if (vector !== 8'hE0) begin n_fail++; $display("FAIL hold_vector got %h want e0", vector); end
        ack_end();
        cfg_write(2'd2, 8'h00);
    endtask

    task automatic test_spurious();
        logic [7:0] rd;
        cfg_read(2'd1, rd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL spur_pre_pending got %h want 00", rd); end
        ack_start();
        n_checks++; if (vector !== SV) begin n_fail++; $display("FAIL spur_vector got %h want fe", vector); end
        n_checks++; if (vector_oe !== 1'b1) begin n_fail++; $display("FAIL spur_oe got %b want 1", vector_oe); end
        n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL spur_in_service got %b want 0", in_service); end
        tick();
        n_checks++; if (vector_oe !== 1'b1) begin n_fail++; $display("FAIL spur_oe_hold got %b want 1", vector_oe); end
        ack_end();
        n_checks++; if (vector_oe !== 1'b0) begin n_fail++; $display("FAIL spur_oe_drop got %b want 0", vector_oe); end
        cfg_write(2'd2, 8'h00);
        cfg_read(2'd2, rd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL spur_eoi_idle got %h want 00", rd); end
        req = 4'b0010; tick(); req = '0; tick();
        n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL spur_after_irq got %b want 0", irq_n); end
        ack_start();
        n_checks++; if (vector !== 8'hE2) begin n_fail++; $display("FAIL spur_after_vec got %h want e2", vector); end
        ack_end();
        cfg_write(2'd2, 8'h00);
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] rd;
        req = 4'b1001; tick(); req = '0; tick();
        ack_start();
        n_checks++; if (vector_oe !== 1'b1) begin n_fail++; $display("FAIL rst_pre_oe got %b want 1", vector_oe); end
        cfg_read(2'd1, rd);
        n_checks++; if (rd !== 8'h08) begin n_fail++; $display("FAIL rst_pre_pending got %h want 08", rd); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (vector_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe got %b want 0", vector_oe); end
        n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL rst_in_service got %b want 0", in_service); end
        n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL rst_irq got %b want 1", irq_n); end
        n_checks++; if (vector !== 8'h00) begin n_fail++; $display("FAIL rst_vector got %h want 00", vector); end
        cfg_read(2'd1, rd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rst_pending got %h want 00", rd); end
        m1_n = 1'b1; iorq_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Reference model: pending set, enable mask, rotate flag and pointer.
    // The winner is the eligible source at the smallest distance from the
    // priority origin (0 when fixed, pointer when rotating), modulo N.
    task automatic test_random();
        logic [N-1:0] m_pend, m_en, hw, sw;
        logic         m_rot;
        int           m_ptr, best, bestd, d;
        logic [7:0]   rd, exp_vec;
        m_pend = '0; m_en = '0; m_rot = 1'b0; m_ptr = 0;
        hold = 1'b1;
        tick();
        for (int it = 0; it < 30; it++) begin
            m_en  = 4'($urandom_range(1, 15));
            m_rot = 1'($urandom_range(0, 1));
            hw    = 4'($urandom_range(0, 15));
            sw    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cfg_write(2'd0, {4'h0, m_en});
            cfg_write(2'd3, {7'h00, m_rot});
            req = hw; tick(); req = '0;
            if (sw != 4'h0) cfg_write(2'd1, {4'h0, sw});
            m_pend = m_pend | hw | sw;
            cfg_read(2'd1, rd);
            n_checks++; if (rd !== {4'h0, m_pend}) begin n_fail++; $display("FAIL rnd_pending it=%0d got %h want %h", it, rd, {4'h0, m_pend}); end
            hold = 1'b0;
            tick(3);
            best = -1; bestd = N;
            for (int id = 0; id < N; id++) begin
                if (m_pend[id] && m_en[id]) begin
                    d = m_rot ? ((id - m_ptr + N) % N) : id;
                    if (d < bestd) begin bestd = d; best = id; end
                end
            end
            if (best < 0) begin
                n_checks++; if (irq_n !== 1'b1) begin n_fail++; $display("FAIL rnd_idle it=%0d got %b want 1", it, irq_n); end
                hold = 1'b1;
            end else begin
                n_checks++; if (irq_n !== 1'b0) begin n_fail++; $display("FAIL rnd_irq it=%0d got %b want 0", it, irq_n); end
                ack_start();
                exp_vec = VB + 8'(2 * best);
                n_checks++; if (vector !== exp_vec) begin n_fail++; $display("FAIL rnd_vector it=%0d got %h want %h", it, vector, exp_vec); end
                n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL rnd_in_service it=%0d got %b want 1", it, in_service); end
                ack_end();
                m_pend[best] = 1'b0;
                hold = 1'b1;
                cfg_write(2'd2, 8'h00);
                if (m_rot) m_ptr = (best + 1) % N;
                n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL rnd_eoi it=%0d got %b want 0", it, in_service); end
            end
        end
        hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fixed_priority();
        test_rotate();
        test_hold();
        test_spurious();
        test_reset_mid_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_scheduler.md
Name: irq_scheduler

Overview:
Synchronous interrupt controller sitting between the mapper's interrupt sources and the Z80 INT pin. It latches edge-triggered requests from N sources and arbitrates them with fixed or rotating priority. It runs the IM2 acknowledge handshake, supplying an even vector on the data bus, and holds further interrupts off until the service routine writes EOI. A hold input gates delivery while the mapper is in trap state; requests keep accumulating during hold.

Parameters:
N_SRC, 4, number of request sources (2..8)
VEC_BASE, 8'hE0, IM2 vector base; must be even; vector = VEC_BASE + 2*id
SPUR_VEC, 8'hFE, vector driven on an acknowledge with no granted source

Ports:
clk  in  1  system clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
m1_n  in  1  Z80 M1, synchronous to clk
iorq_n  in  1  Z80 IORQ, synchronous to clk
req  in  N_SRC  per-source request; rising edge sets pending
hold  in  1  high = irq_n forced high (trap state)
cfg_wr  in  1  one-cycle register write strobe
cfg_rd  in  1  register read select
cfg_addr  in  2  register select
cfg_wdata  in  8  write data
cfg_rdata  out  8  read data, combinational from cfg_addr when cfg_rd, else 0
irq_n  out  1  registered interrupt to CPU
vector  out  8  vector byte
vector_oe  out  1  high while vector must drive the data bus
in_service  out  1  high from acknowledge until EOI

Behaviour:
- Reset: irq_n=1, vector_oe=0, vector=0, in_service=0, pending=0, enable=0, rotate=0, rr_ptr=0, req_q=0, state IDLE.
- Registers (cfg_addr): 0 enable[N-1:0] R/W; 1 pending R, write-1-sets (software trigger); 2 write = EOI (data ignored), read = {in_service, 4'b0, id[2:0]}; 3 bit0 rotate R/W, other bits read 0.
- Edge detect: req_q <= req; pending[i] set when req[i] & ~req_q[i]. Set wins over same-cycle clear.
- Eligible = pending & enable. Winner: fixed mode, lowest index; rotate mode, first eligible index at or after rr_ptr, wrapping modulo N_SRC.
- Ack detect: ack = ~m1_n & ~iorq_n; ack_rise = ack & ~ack_q.
- State machine:
  - IDLE: irq_n=1. If ~hold & |eligible: latch winner into id, go ASSERT; irq_n=0 at that same edge.
  - ASSERT: irq_n=0. If eligible[id] drops or hold rises, go IDLE and irq_n=1 next edge (retraction). On ack_rise: vector=VEC_BASE+2*id, vector_oe=1, clear pending[id], in_service=1, irq_n=1, go ACK.
  - ACK: vector_oe=1 while ack; when ack falls, vector_oe=0, go SERVICE.
  - SERVICE: irq_n=1. EOI write: in_service=0, rr_ptr=(id+1) mod N_SRC if rotate, go IDLE. New requests only pend.
- EOI in any state other than SERVICE is ignored.
- ack_rise in IDLE or SERVICE (spurious): vector=SPUR_VEC, vector_oe=1 for the ack duration; no other state change.
- Latency: req high at edge k gives pending at edge k+1 and irq_n=0 at edge k+2. Ack is seen at edge a, giving vector_oe=1 after edge a.
- Enable writes and hold changes take effect on the next arbitration. The winner is re-evaluated only in IDLE.
- Asynchronous reset at any point, including mid-ack, returns every output to reset values immediately.

Test Plan:
- enable=4'hF, rotate=0; pulse req[2], then ack -> irq_n low 2 clks after req; vector=8'hE4 with vector_oe for the ack; pending[2]=0; in_service=1; irq_n stays high until EOI.
- req[3] and req[1] in the same cycle, fixed priority -> first ack vector 8'hE2; after EOI, second ack vector 8'hE6.
- rotate=1; serve src0 and EOI; then raise req0 and req1 together -> vector 8'hE2 (rr_ptr=1); after EOI, vector 8'hE0.
- hold=1 with req[0] pulsed -> irq_n stays 1 and pending=1; release hold -> irq_n=0 two clks later. hold rising in ASSERT -> irq_n=1 next clk.
- ack with nothing pending -> vector=8'hFE and vector_oe=1; state and pending unchanged. EOI written in IDLE -> no effect.
- reset_n low during ACK with vector_oe=1 -> vector_oe, in_service and pending drop immediately; irq_n=1.
